// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, error result,
// FSM state encoding and the legal-opcode decoder.
package alu_pkg;

    localparam logic [7:0] OP_ADD   = 8'h00;
    localparam logic [7:0] OP_SUB   = 8'h01;
    localparam logic [7:0] OP_MUL   = 8'h02;
    localparam logic [7:0] OP_DIV   = 8'h03;
    localparam logic [7:0] OP_MOD   = 8'h13;
    localparam logic [7:0] OP_CMP   = 8'h04;
    localparam logic [7:0] OP_NOT   = 8'h08;
    localparam logic [7:0] OP_AND   = 8'h09;
    localparam logic [7:0] OP_OR    = 8'h0A;
    localparam logic [7:0] OP_XOR   = 8'h0B;
    localparam logic [7:0] OP_SHL   = 8'h10;
    localparam logic [7:0] OP_SHR   = 8'h11;
    localparam logic [7:0] OP_LOADI = 8'hF0;

    localparam logic [7:0] DIV0_RESULT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // True only for opcodes the external ALU implements; LOADI is handled separately.
    function automatic logic is_legal_op(input logic [7:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_CMP,
            OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, ALU operand bus and retire signals of the issue controller.
// master = decode/ALU side, slave = the controller.
interface alu_issue_ctrl_if #(
    parameter int REG_AW = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_op;
    logic [REG_AW-1:0] in_rd;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [7:0]        in_imm;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [7:0]        alu_op;
    logic [7:0]        alu_result;
    logic              done;
    logic [7:0]        done_data;
    logic              err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, alu_result,
        input  in_ready, alu_a, alu_b, alu_op, done, done_data, err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, alu_result,
        output in_ready, alu_a, alu_b, alu_op, done, done_data, err
    );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x 8 register file: one synchronous write port, two operand read ports
// and a debug read port, all reads combinational; asynchronous clear.
module alu_regfile #(
    parameter int NREGS  = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [7:0]        rdata1_o,
    output logic [7:0]        rdata2_o,
    output logic [7:0]        dbg_data_o
);

    logic [7:0] mem_q [NREGS];

    // Storage array with asynchronous clear and single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o   = mem_q[raddr1_i];
    assign rdata2_o   = mem_q[raddr2_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction, drives the external ALU for one
// cycle, then retires it with a done pulse and register write-back.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS  = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [7:0]        dbg_data
);

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [7:0]        alu_a_q, alu_a_d;
    logic [7:0]        alu_b_q, alu_b_d;
    logic [7:0]        alu_op_q, alu_op_d;
    logic [7:0]        imm_q, imm_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [7:0]        res_q, res_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic [7:0]        rs1_data_s;
    logic [7:0]        rs2_data_s;
    logic              rf_we_s;

    // Write-back happens at the end of the WB cycle, only for error-free results.
    assign rf_we_s = done_q & ~err_q;

    alu_regfile #(
        .NREGS  (NREGS),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (rf_we_s),
        .waddr_i    (rd_q),
        .wdata_i    (res_q),
        .raddr1_i   (bus.in_rs1),
        .raddr2_i   (bus.in_rs2),
        .dbg_addr_i (dbg_sel),
        .rdata1_o   (rs1_data_s),
        .rdata2_o   (rs2_data_s),
        .dbg_data_o (dbg_data)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            alu_op_q   <= 8'h00;
            imm_q      <= 8'h00;
            rd_q       <= '0;
            res_q      <= 8'h00;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            res_q      <= res_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // Next-state and result selection; operand registers double as the ALU drive.
    always_comb begin
        state_d  = state_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        imm_d    = imm_q;
        rd_d     = rd_q;
        res_d    = res_q;
        err_d    = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    alu_a_d  = rs1_data_s;
                    alu_b_d  = rs2_data_s;
                    alu_op_d = bus.in_op;
                    imm_d    = bus.in_imm;
                    rd_d     = bus.in_rd;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                done_d  = 1'b1;
                state_d = ST_WB;
                if (alu_op_q == OP_LOADI) begin
                    res_d = imm_q;
                    err_d = 1'b0;
                end else if (!is_legal_op(alu_op_q)) begin
                    res_d = 8'h00;
                    err_d = 1'b1;
                end else if (((alu_op_q == OP_DIV) || (alu_op_q == OP_MOD)) &&
                             (alu_b_q == 8'h00)) begin
                    res_d = DIV0_RESULT;
                    err_d = 1'b1;
                end else begin
                    res_d = bus.alu_result;
                    err_d = 1'b0;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE) begin
            in_ready_d = 1'b1;
        end else begin
            in_ready_d = 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.done      = done_q;
    assign bus.done_data = res_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU drives alu_result and
// a register-file model predicts every retire, write-back and debug read.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [7:0] imm;
        logic [7:0] exp;
        logic       eerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_rf [4];
    logic [7:0] m_a, m_b, m_res;
    logic       m_err;

    logic [7:0] obs_a, obs_b, obs_op, obs_data;
    logic       obs_err, obs_rdy_exec, obs_rdy_wb;
    int         obs_lat;

    logic [7:0] legal_ops [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h13, 8'h04,
                                   8'h08, 8'h09, 8'h0A, 8'h0B, 8'h10, 8'h11};

    alu_issue_ctrl_if #(.REG_AW(2)) bus ();

    alu_issue_ctrl #(.NREGS(4), .REG_AW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Bench ALU; returns junk on divide-by-zero so the controller must override it.
    function automatic logic [7:0] alu_model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            8'h00:   return a + b;
            8'h01:   return a - b;
            8'h02:   return 8'((a * b) & 16'h00FF);
            8'h03:   return (b == 8'h00) ? 8'h11 : a / b;
            8'h13:   return (b == 8'h00) ? 8'h22 : a % b;
            8'h04:   return (a == b) ? 8'h00 : ((a < b) ? 8'h01 : 8'h02);
            8'h08:   return ~a;
            8'h09:   return a & b;
            8'h0A:   return a | b;
            8'h0B:   return a ^ b;
            8'h10:   return (b >= 8'd8) ? 8'h00 : 8'(a << b[2:0]);
            8'h11:   return (b >= 8'd8) ? 8'h00 : 8'(a >> b[2:0]);
            default: return 8'hA5;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

    // Architectural model: predicts result/err and commits the write.
    task automatic model_step(input logic [7:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                              input logic [1:0] rs2, input logic [7:0] imm);
        m_a = ref_rf[rs1];
        m_b = ref_rf[rs2];
        if (op == 8'hF0) begin
            m_res = imm; m_err = 1'b0;
        end else if (!(op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h13, 8'h04,
                                  8'h08, 8'h09, 8'h0A, 8'h0B, 8'h10, 8'h11})) begin
            m_res = 8'h00; m_err = 1'b1;
        end else if ((op == 8'h03 || op == 8'h13) && m_b == 8'h00) begin
            m_res = 8'hFF; m_err = 1'b1;
        end else begin
            m_res = alu_model(op, m_a, m_b); m_err = 1'b0;
        end
        if (!m_err) ref_rf[rd] = m_res;
    endtask

    // Issue one instruction and record what the DUT does until the done pulse.
    task automatic run_instr(input logic [7:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [7:0] imm);
        int w;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_rd = rd;
        bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 8) begin
            @(negedge clk); w++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_op = 8'($urandom); bus.in_rd = 2'($urandom);
        bus.in_rs1 = 2'($urandom); bus.in_rs2 = 2'($urandom); bus.in_imm = 8'($urandom);
        obs_a = bus.alu_a; obs_b = bus.alu_b; obs_op = bus.alu_op;
        obs_rdy_exec = bus.in_ready;
        obs_lat = -1; obs_data = 8'h00; obs_err = 1'b0; obs_rdy_wb = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (bus.done === 1'b1) begin
                obs_lat = k; obs_data = bus.done_data; obs_err = bus.err;
                obs_rdy_wb = bus.in_ready;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_idle();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.alu_op !== 8'h00) begin errors++; $display("FAIL rst_alu_op: got %h want 00", bus.alu_op); end
        checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_done_err: got %b%b want 00", bus.done, bus.err); end
        checks++; if (bus.done_data !== 8'h00) begin errors++; $display("FAIL rst_done_data: got %h want 00", bus.done_data); end
    endtask

    task automatic test_reset();
        logic seen_done;
        model_step(8'hF0, 2'd1, 2'd0, 2'd0, 8'h33);
        run_instr(8'hF0, 2'd1, 2'd0, 2'd0, 8'h33);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 8'h00; bus.in_rd = 2'd0; bus.in_rs1 = 2'd1; bus.in_rs2 = 2'd1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.alu_op !== 8'h00 || bus.alu_a !== 8'h33) begin errors++; $display("FAIL exec_drive: got op %h a %h want 00 33", bus.alu_op, bus.alu_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.alu_op !== 8'h00 || bus.alu_a !== 8'h00) begin errors++; $display("FAIL midrst_alu: got op %h a %h want 00 00", bus.alu_op, bus.alu_a); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ref_rf[i] = 8'h00;
            if (bus.done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got done=1 want no done"); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL midrst_dbg r%0d: got %h want 00", i, dbg_data); end
        end
    endtask

    task automatic test_loadi_add();
        vec_t v [3];
        v[0] = '{8'hF0, 2'd1, 2'd0, 2'd0, 8'h07, 8'h07, 1'b0};
        v[1] = '{8'hF0, 2'd2, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0};
        v[2] = '{8'h00, 2'd0, 2'd1, 2'd2, 8'h99, 8'h0C, 1'b0};
        for (int i = 0; i < 3; i++) begin
            model_step(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            run_instr(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            checks++; if (obs_lat !== 2) begin errors++; $display("FAIL add_latency[%0d]: got %0d want 2", i, obs_lat); end
            checks++; if (obs_data !== v[i].exp || obs_err !== v[i].eerr) begin errors++; $display("FAIL add_result[%0d]: got %h/%b want %h/%b", i, obs_data, obs_err, v[i].exp, v[i].eerr); end
            checks++; if (obs_rdy_exec !== 1'b0 || obs_rdy_wb !== 1'b0) begin errors++; $display("FAIL add_ready[%0d]: got %b%b want 00", i, obs_rdy_exec, obs_rdy_wb); end
        end
        @(negedge clk); dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 8'h0C) begin errors++; $display("FAIL add_dbg_r0: got %h want 0c", dbg_data); end
    endtask

    task automatic test_arith();
        vec_t v [9];
        v[0] = '{8'hF0, 2'd1, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0};
        v[1] = '{8'hF0, 2'd2, 2'd0, 2'd0, 8'h03, 8'h03, 1'b0};
        v[2] = '{8'h02, 2'd3, 2'd1, 2'd2, 8'h00, 8'hD0, 1'b0};
        v[3] = '{8'h03, 2'd3, 2'd1, 2'd2, 8'h00, 8'h50, 1'b0};
        v[4] = '{8'hF0, 2'd1, 2'd0, 2'd0, 8'h0E, 8'h0E, 1'b0};
        v[5] = '{8'h13, 2'd3, 2'd1, 2'd2, 8'h00, 8'h02, 1'b0};
        v[6] = '{8'hF0, 2'd2, 2'd0, 2'd0, 8'h08, 8'h08, 1'b0};
        v[7] = '{8'h10, 2'd3, 2'd1, 2'd2, 8'h00, 8'h00, 1'b0};
        v[8] = '{8'h01, 2'd0, 2'd2, 2'd1, 8'h00, 8'hFA, 1'b0};
        for (int i = 0; i < 9; i++) begin
            model_step(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            run_instr(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            checks++; if (obs_data !== v[i].exp || obs_err !== v[i].eerr || obs_lat !== 2) begin errors++; $display("FAIL arith[%0d]: got %h/%b lat %0d want %h/%b lat 2", i, obs_data, obs_err, obs_lat, v[i].exp, v[i].eerr); end
        end
    endtask

    task automatic test_div_zero();
        vec_t v [5];
        v[0] = '{8'hF0, 2'd3, 2'd0, 2'd0, 8'h55, 8'h55, 1'b0};
        v[1] = '{8'hF0, 2'd2, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0};
        v[2] = '{8'hF0, 2'd1, 2'd0, 2'd0, 8'h40, 8'h40, 1'b0};
        v[3] = '{8'h03, 2'd3, 2'd1, 2'd2, 8'h00, 8'hFF, 1'b1};
        v[4] = '{8'h13, 2'd3, 2'd1, 2'd2, 8'h00, 8'hFF, 1'b1};
        for (int i = 0; i < 5; i++) begin
            model_step(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            run_instr(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            checks++; if (obs_data !== v[i].exp || obs_err !== v[i].eerr) begin errors++; $display("FAIL div0[%0d]: got %h/%b want %h/%b", i, obs_data, obs_err, v[i].exp, v[i].eerr); end
        end
        @(negedge clk); dbg_sel = 2'd3; #1;
        checks++; if (dbg_data !== 8'h55) begin errors++; $display("FAIL div0_r3_kept: got %h want 55", dbg_data); end
    endtask

    task automatic test_illegal();
        logic [7:0] ill [3] = '{8'h05, 8'hFF, 8'h12};
        for (int i = 0; i < 3; i++) begin
            model_step(ill[i], 2'd0, 2'd1, 2'd3, 8'h77);
            run_instr(ill[i], 2'd0, 2'd1, 2'd3, 8'h77);
            checks++; if (obs_data !== 8'h00 || obs_err !== 1'b1) begin errors++; $display("FAIL illegal[%h]: got %h/%b want 00/1", ill[i], obs_data, obs_err); end
            checks++; if (obs_op !== ill[i]) begin errors++; $display("FAIL illegal_aluop[%h]: got %h want %h", ill[i], obs_op, ill[i]); end
        end
        @(negedge clk); dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 8'hFA) begin errors++; $display("FAIL illegal_r0_kept: got %h want fa", dbg_data); end
    endtask

    task automatic test_back_to_back();
        vec_t v [3];
        v[0] = '{8'h00, 2'd1, 2'd1, 2'd1, 8'h00, 8'h02, 1'b0};
        v[1] = '{8'h00, 2'd2, 2'd1, 2'd1, 8'h00, 8'h04, 1'b0};
        v[2] = '{8'h00, 2'd0, 2'd2, 2'd1, 8'h00, 8'h06, 1'b0};
        model_step(8'hF0, 2'd1, 2'd0, 2'd0, 8'h81);
        run_instr(8'hF0, 2'd1, 2'd0, 2'd0, 8'h81);
        checks++; if (obs_data !== 8'h81) begin errors++; $display("FAIL b2b_load: got %h want 81", obs_data); end
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            checks++; if (bus.in_ready !== (c % 3 == 0)) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, bus.in_ready, (c % 3 == 0)); end
            if (c % 3 == 0) begin
                bus.in_op = v[c/3].op; bus.in_rd = v[c/3].rd; bus.in_rs1 = v[c/3].rs1;
                bus.in_rs2 = v[c/3].rs2; bus.in_imm = v[c/3].imm;
                model_step(v[c/3].op, v[c/3].rd, v[c/3].rs1, v[c/3].rs2, v[c/3].imm);
            end else if (c % 3 == 2) begin
                checks++; if (bus.done !== 1'b1 || bus.done_data !== v[c/3].exp || bus.err !== 1'b0) begin errors++; $display("FAIL b2b_done[%0d]: got %b %h %b want 1 %h 0", c/3, bus.done, bus.done_data, bus.err, v[c/3].exp); end
            end else begin
                checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_exec_done[%0d]: got 1 want 0", c/3); end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [7:0] imm;
        int pick;
        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 15));
            if (pick < 12) op = legal_ops[pick];
            else if (pick < 14) op = 8'hF0;
            else op = 8'($urandom);
            rd = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom); imm = 8'($urandom);
            model_step(op, rd, rs1, rs2, imm);
            run_instr(op, rd, rs1, rs2, imm);
            checks++; if (obs_a !== m_a || obs_b !== m_b || obs_op !== op) begin errors++; $display("FAIL rnd_drive[%0d]: got %h %h %h want %h %h %h", n, obs_op, obs_a, obs_b, op, m_a, m_b); end
            checks++; if (obs_data !== m_res || obs_err !== m_err || obs_lat !== 2) begin errors++; $display("FAIL rnd_result[%0d] op %h: got %h/%b lat %0d want %h/%b lat 2", n, op, obs_data, obs_err, obs_lat, m_res, m_err); end
            @(negedge clk); dbg_sel = 2'($urandom); #1;
            checks++; if (dbg_data !== ref_rf[dbg_sel]) begin errors++; $display("FAIL rnd_dbg[%0d] r%0d: got %h want %h", n, dbg_sel, dbg_data, ref_rf[dbg_sel]); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 8'h00; bus.in_rd = 2'd0;
        bus.in_rs1 = 2'd0; bus.in_rs2 = 2'd0; bus.in_imm = 8'h00;
        dbg_sel = 2'd0;
        for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
        repeat (2) @(negedge clk);
        test_reset_idle();
        rst_n = 1'b1;
        test_reset();
        test_loadi_add();
        test_arith();
        test_div_zero();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU op/operand interface. Accepts one instruction per valid/ready handshake and reads operands from a small internal register file.
- Drives the 8-bit op and a/b operands to the combinational ALU, captures the ALU result, and writes it back to the destination register.
- Sits between the microprocessor fetch/decode logic and the ALU. It serialises instructions, so no hazard logic is needed.

Parameters:
- NREGS, 4, number of 8-bit registers. Must be a power of two, at least 2.
- REG_AW, 2, register index width. Must equal log2(NREGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  controller can accept an instruction.
- in_op  in  8  ALU opcode, or LOADI (8'hF0).
- in_rd  in  REG_AW  destination register index.
- in_rs1  in  REG_AW  source register for operand a.
- in_rs2  in  REG_AW  source register for operand b.
- in_imm  in  8  immediate, used only by LOADI.
- alu_a  out  8  operand a to the ALU.
- alu_b  out  8  operand b to the ALU.
- alu_op  out  8  opcode to the ALU.
- alu_result  in  8  combinational result from the ALU.
- done  out  1  one-cycle pulse when an instruction retires.
- done_data  out  8  value written back; valid while done=1.
- err  out  1  one-cycle pulse with done for an illegal op or divide/modulo by zero.
- dbg_sel  in  REG_AW  debug read index.
- dbg_data  out  8  combinational read of register dbg_sel.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state goes to IDLE and all registers clear to 0.
  - alu_a, alu_b and alu_op go to 0; done, done_data and err go to 0; in_ready goes to 1.
  - Any in-flight instruction is discarded with no done and no writeback.
- Legal ALU ops: 00, 01, 02, 03, 13, 04, 08, 09, 0A, 0B, 10, 11 (hex). LOADI = F0. Every other code is illegal.
- FSM has three states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch op and rd. Latch a_q=rf[rs1] and b_q=rf[rs2], read at the accept edge. Go to EXEC.
- EXEC (exactly one cycle):
  - alu_a/alu_b/alu_op are registered: loaded from a_q/b_q/op_q on entry and held until the next instruction's EXEC.
  - On exit, res_q captures the value selected by the first matching rule:
    - LOADI: the latched imm. The ALU outputs still update, but alu_result is ignored.
    - Illegal op: res_q = 8'h00, err_q=1.
    - Op 03 or 13 with b_q==0: res_q = 8'hFF, err_q=1. The ALU result is ignored.
    - Otherwise: alu_result.
  - Go to WB.
- WB (exactly one cycle):
  - done=1 and done_data=res_q; err=err_q.
  - If err_q=0, write rf[rd]=res_q. If err_q=1, no register write.
  - Go to IDLE.
- Latency and throughput: accept at edge T; ALU drive stable during cycle T+1; done high during cycle T+2; register write visible at edge T+3. Throughput is 1 instruction per 3 cycles; in_ready=0 during EXEC and WB.
- Self-dependency: rd equal to rs1 or rs2 is legal. Source values are those from before the write.
- Back-to-back instructions: the next instruction accepted in the IDLE following WB sees the updated register file. There is no bypass requirement.
- Source reads: operands are read at the accept edge, so an instruction whose sources equal the previous rd reads the new value.
- Arithmetic: all widths are 8 bits. Overflow and truncation follow the ALU (mul low 8 bits, shift by b ≥ 8 gives 0). Compare writes the ALU's 2-bit code zero-extended.
- Debug port: dbg_data = rf[dbg_sel]. It updates on the cycle after a write.
- Handshake: in_* inputs are sampled only on the accept edge. Inputs are don't-care otherwise, and in_valid may drop without penalty.

Decomposition:
- Shared package `alu_pkg`:
  - opcode localparams: OP_ADD=00, OP_SUB=01, OP_MUL=02, OP_DIV=03, OP_MOD=13, OP_CMP=04, OP_NOT=08, OP_AND=09, OP_OR=0A, OP_XOR=0B, OP_SHL=10, OP_SHR=11, OP_LOADI=F0.
  - DIV0_RESULT=8'hFF.
  - FSM state encoding.
  - is_legal_op function.
- Natural sub-module: `alu_regfile` (NREGS x 8, one synchronous write port, two combinational read ports plus the debug read port, async clear).
- The ALU itself stays external and is instantiated alongside at the top level.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC of an ADD -> in_ready=1, alu_op=0, no done, and dbg_data=0 for every register after release.
- LOADI r1=7, LOADI r2=5, ADD r0=r1+r2 -> third done has done_data=0x0C, err=0, and dbg r0=0x0C. done lands exactly 2 cycles after each accept.
- r1=0xF0, r2=0x03: MUL r3 -> 0xD0; DIV r3 -> 0x50; MOD r3 (r1=0x0E, r2=0x03) -> 0x02; SHL by 8 -> 0x00.
- r2=0: DIV r3=r1/r2 with r3 preloaded 0x55 -> done_data=0xFF, err=1, r3 stays 0x55. Same result for MOD.
- Illegal op 0x05 -> done_data=0x00, err=1, no register write.
- Hold in_valid=1 continuously with 3 queued ops -> in_ready pattern 1,0,0 repeating; ADD r1=r1+r1 with r1=0x81 gives 0x02; the next op reads 0x02.
